bus_mem_ctrl: RTL and testbench
===============================

Name: bus_mem_ctrl

Overview:
Bus target that sits directly downstream of cpu's mem_bus port and terminates its requests on a single-port synchronous SRAM.
- Accepts one request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states.
- Performs byte/half/word lane alignment, byte-enable generation and load sign/zero extension.
- Returns a single-cycle response carrying read data or an error flag.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address mapped to SRAM word 0
MEM_WORDS, 16384, SRAM depth in 32-bit words; the address range is BASE_ADDR .. BASE_ADDR+4*MEM_WORDS-1
WAIT_STATES, 0, extra idle cycles between request accept and the SRAM access (0..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_addr  in  32  byte address
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word (3 is illegal and returns an error)
req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, out-of-range or illegal-size request
sram_en  out  1  SRAM access strobe
sram_we  out  1  SRAM write enable
sram_be  out  4  SRAM byte enables
sram_addr  out  $clog2(MEM_WORDS)  word index
sram_wdata  out  32  lane-aligned write data
sram_rdata  in  32  read data, valid the cycle after sram_en with sram_we=0

Behaviour:
- Reset (rst=0, asynchronous): state goes to IDLE; req_ready, resp_valid, resp_err, sram_en, sram_we and sram_be are 0; resp_rdata, sram_addr and sram_wdata are 0.
- Reset asserted mid-transaction aborts it. No response is produced and no SRAM write occurs after rst falls.
- FSM states: IDLE, WAIT, ACCESS, READ, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch addr, we, size, unsigned and wdata.
  - Next state: RESP with err=1 on a bad request, else WAIT if WAIT_STATES>0, else ACCESS.
- Bad request, any of:
  - size==3;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr<BASE_ADDR;
  - (addr-BASE_ADDR)>>2 >= MEM_WORDS.
- WAIT: a 4-bit counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0, go to ACCESS.
- ACCESS: sram_en=1 for exactly one cycle; sram_we=we; sram_addr=(addr-BASE_ADDR)>>2.
  - Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
  - sram_wdata: wdata replicated per lane (byte into all four lanes, half into both halves).
  - Loads go to READ; stores go to RESP.
- READ: capture sram_rdata.
  - Select the lane by addr[1:0] and size.
  - Extend to 32 bits per req_unsigned.
  - Go to RESP.
- RESP: resp_valid=1 for one cycle with rdata/err registered; then IDLE. There is no response backpressure: the upstream must accept it.
- req_ready is 0 in every state except IDLE. At most one outstanding request.
- Latency, measured from the accept edge (cycle 0), W=WAIT_STATES:
  - store resp_valid at cycle 2+W;
  - load resp_valid at cycle 3+W;
  - error resp_valid at cycle 1.
- The next request can be accepted in the cycle after RESP.
- Back-to-back throughput: one store per 3+W cycles; one load per 4+W cycles.
- Address arithmetic is 32-bit unsigned with no wrap: an address past the end of the range errors and must not alias.

Decomposition:
- Package bus_pkg:
  - size_t enum (SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2);
  - mem_state_t enum (IDLE, WAIT, ACCESS, READ, RESP);
  - request struct (addr, we, size, unsigned, wdata).
- Sub-module mem_lane_align, combinational: generates byte enables and replicated wdata from size/addr[1:0]; performs load lane extraction and extension. It is shared by the store and load paths.
- The FSM, the wait counter and the capture registers stay in bus_mem_ctrl.

Test Plan:
1. WAIT_STATES=0: word store 32'hDEADBEEF to 0x10, then word load 0x10 -> sram_be=4'b1111, sram_addr=4; store resp at cycle 2, load resp at cycle 3 with resp_rdata=32'hDEADBEEF, resp_err=0.
2. Byte store 8'h80 to 0x13, then loads of 0x13 with req_unsigned=0 and =1 -> sram_be=4'b1000; resp_rdata=32'hFFFFFF80 and 32'h00000080 respectively.
3. Half load from 0x11, word load from 0x12, req_size=3 -> resp_err=1, resp_rdata=0, resp_valid at cycle 1, sram_en never asserted.
4. MEM_WORDS=16: load 0x40 and store 0xFFFF_FFFC -> resp_err=1, no SRAM write.
5. WAIT_STATES=3: load -> sram_en at cycle 4, resp_valid at cycle 6; req_ready=0 on cycles 1-6 while req_valid is held high.
6. rst driven low during WAIT of a store -> all outputs 0 immediately, no sram_en, no resp_valid; after release req_ready=1 and the next request completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared types for the memory-bus target
package bus_pkg;
  typedef enum logic [1:0] {SIZE_BYTE = 2'd0, SIZE_HALF = 2'd1, SIZE_WORD = 2'd2} size_t;
  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, READ, RESP} mem_state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } request_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-enable/write-lane replication and load lane extraction with extension
module mem_lane_align
  import bus_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_uns,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic        w_byte;
  logic        w_half;
  logic [15:0] w_lane;
  assign w_byte  = i_size == SIZE_BYTE;
  assign w_half  = i_size == SIZE_HALF;
  assign w_lane  = 16'(i_rdata >> {i_off, 3'b000});
  assign o_be    = w_byte ? 4'b0001 << i_off : w_half ? 4'b0011 << i_off : 4'b1111;
  assign o_wdata = w_byte ? {4{i_wdata[7:0]}} : w_half ? {2{i_wdata[15:0]}} : i_wdata;
  assign o_rdata = w_byte ? {{24{~i_uns & w_lane[7]}}, w_lane[7:0]}
                 : w_half ? {{16{~i_uns & w_lane[15]}}, w_lane}
                 : i_rdata;
endmodule

// File: rtl/bus_mem_ctrl.sv
// bus_mem_ctrl: single-outstanding bus target terminating requests on a synchronous SRAM
module bus_mem_ctrl
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 16384,
  parameter int          WAIT_STATES = 0,
  localparam int         AW          = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          sram_en,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);
  mem_state_t  r_state, w_next;
  request_t    r_req;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] w_off;
  logic        w_bad;
  logic        w_acc;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;
  assign w_acc = req_valid && r_state == IDLE;
  assign w_off = req_addr - BASE_ADDR;
  // range check is done on the unwrapped offset so addresses past the end never alias
  assign w_bad = req_size == 2'd3
              || (req_size == SIZE_HALF && req_addr[0])
              || (req_size == SIZE_WORD && |req_addr[1:0])
              || req_addr < BASE_ADDR
              || (w_off >> 2) >= 32'(MEM_WORDS);
  mem_lane_align u_align (
    .i_size (r_req.size),
    .i_off  (r_req.addr[1:0]),
    .i_uns  (r_req.uns),
    .i_wdata(r_req.wdata),
    .i_rdata(sram_rdata),
    .o_be   (w_be),
    .o_wdata(w_wdata),
    .o_rdata(w_ext)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = w_bad ? RESP : (WAIT_STATES > 0 ? WAIT : ACCESS);
      WAIT:    if (r_cnt == 4'd0) w_next = ACCESS;
      ACCESS:  w_next = r_req.we ? RESP : READ;
      READ:    w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_req   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_req   <= '{addr: req_addr, we: req_we, size: req_size, uns: req_unsigned, wdata: req_wdata};
        r_err   <= w_bad;
        r_rdata <= '0;
        r_cnt   <= 4'(WAIT_STATES - 1);
      end else if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
      if (r_state == READ) r_rdata <= w_ext;
    end
  always_comb begin
    req_ready  = rst && r_state == IDLE;
    sram_en    = r_state == ACCESS;
    sram_we    = sram_en && r_req.we;
    sram_be    = sram_en ? w_be : 4'b0000;
    sram_addr  = sram_en ? AW'((r_req.addr - BASE_ADDR) >> 2) : '0;
    sram_wdata = sram_en ? w_wdata : 32'h0;
    resp_valid = r_state == RESP;
    resp_rdata = resp_valid ? r_rdata : 32'h0;
    resp_err   = resp_valid && r_err;
  end
endmodule

// File: tb/tb_bus_mem_ctrl.sv
// tb_bus_mem_ctrl: directed checks of two controller configurations (no wait states / 16 words, and 3 wait states)
module tb_bus_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rdy[2], rv[2], er[2], en[2], swe[2];
  logic [3:0]  be[2];
  logic [31:0] rd[2], swd[2], srd[2];
  logic [3:0]  sa0;
  logic [13:0] sa1;
  logic [31:0] mem0[16];
  logic [31:0] mem1[16384];
  int          wcnt0 = 0, wcnt1 = 0;
  int          n_chk = 0, n_fail = 0;
  int          m_lat, m_en_cyc, m_en_cnt;
  logic        m_rdy_seen, m_err, m_swe;
  logic [31:0] m_rdata, m_swd, m_sa;
  logic [3:0]  m_be;
  always #5 clk = ~clk;
  bus_mem_ctrl #(.MEM_WORDS(16), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(er[0]), .sram_en(en[0]), .sram_we(swe[0]),
    .sram_be(be[0]), .sram_addr(sa0), .sram_wdata(swd[0]), .sram_rdata(srd[0])
  );
  bus_mem_ctrl #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(er[1]), .sram_en(en[1]), .sram_we(swe[1]),
    .sram_be(be[1]), .sram_addr(sa1), .sram_wdata(swd[1]), .sram_rdata(srd[1])
  );
  always @(posedge clk) if (en[0]) begin
    if (swe[0]) begin
      for (int b = 0; b < 4; b++) if (be[0][b]) mem0[sa0][8*b +: 8] <= swd[0][8*b +: 8];
      wcnt0 <= wcnt0 + 1;
    end else srd[0] <= mem0[sa0];
  end
  always @(posedge clk) if (en[1]) begin
    if (swe[1]) begin
      for (int b = 0; b < 4; b++) if (be[1][b]) mem1[sa1][8*b +: 8] <= swd[1][8*b +: 8];
      wcnt1 <= wcnt1 + 1;
    end else srd[1] <= mem1[sa1];
  end
  task automatic run(input int s, input logic [31:0] a, input logic we, input logic [1:0] sz,
                     input logic u, input logic [31:0] wd, input bit hold);
    m_lat = -1; m_en_cyc = -1; m_en_cnt = 0; m_rdy_seen = 1'b0;
    m_err = 1'b0; m_swe = 1'b0; m_rdata = '0; m_swd = '0; m_sa = '0; m_be = '0;
    for (int i = 0; i < 40 && !rdy[s]; i++) @(negedge clk);
    req_addr = a; req_we = we; req_size = sz; req_unsigned = u; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 if (!hold) req_valid = 1'b0;
    for (int c = 1; c <= 20 && m_lat < 0; c++) begin
      @(negedge clk);
      if (rdy[s]) m_rdy_seen = 1'b1;
      if (en[s]) begin
        m_en_cnt++; m_en_cyc = c; m_be = be[s]; m_swd = swd[s]; m_swe = swe[s];
        m_sa = s == 0 ? 32'(sa0) : 32'(sa1);
      end
      if (rv[s]) begin m_lat = c; m_rdata = rd[s]; m_err = er[s]; end
    end
    req_valid = 1'b0;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_chk++; if ({rdy[0], rv[0], er[0], en[0], swe[0], be[0], sa0, swd[0], rd[0]} !== '0) begin n_fail++; $display("FAIL reset_outs0: got nonzero outputs rdy=%b rv=%b en=%b be=%h", rdy[0], rv[0], en[0], be[0]); end
    n_chk++; if ({rdy[1], rv[1], er[1], en[1], swe[1], be[1], sa1, swd[1], rd[1]} !== '0) begin n_fail++; $display("FAIL reset_outs3: got nonzero outputs rdy=%b rv=%b en=%b be=%h", rdy[1], rv[1], en[1], be[1]); end
    rst = 1'b1;
    #1;
    n_chk++; if ({rdy[0], rdy[1]} !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b want 11", {rdy[0], rdy[1]}); end
  endtask
  task automatic test_word;
    run(0, 32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
    n_chk++; if (m_lat !== 2) begin n_fail++; $display("FAIL word_st_lat: got %0d want 2", m_lat); end
    n_chk++; if ({m_en_cyc, m_swe, m_be, m_sa} !== {32'd1, 1'b1, 4'b1111, 32'd4}) begin n_fail++; $display("FAIL word_st_sram: got cyc=%0d we=%b be=%b addr=%0d want 1 1 1111 4", m_en_cyc, m_swe, m_be, m_sa); end
    n_chk++; if (m_swd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_st_wdata: got %h want deadbeef", m_swd); end
    n_chk++; if ({m_err, m_rdata} !== 33'h0) begin n_fail++; $display("FAIL word_st_resp: got err=%b rdata=%h want 0 0", m_err, m_rdata); end
    run(0, 32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
    n_chk++; if (m_lat !== 3) begin n_fail++; $display("FAIL word_ld_lat: got %0d want 3", m_lat); end
    n_chk++; if ({m_swe, m_be, m_sa} !== {1'b0, 4'b1111, 32'd4}) begin n_fail++; $display("FAIL word_ld_sram: got we=%b be=%b addr=%0d want 0 1111 4", m_swe, m_be, m_sa); end
    n_chk++; if ({m_err, m_rdata} !== {1'b0, 32'hDEADBEEF}) begin n_fail++; $display("FAIL word_ld_data: got err=%b rdata=%h want 0 deadbeef", m_err, m_rdata); end
  endtask
  task automatic test_byte;
    run(0, 32'h13, 1'b1, 2'd0, 1'b0, 32'h0000_0080, 1'b0);
    n_chk++; if ({m_be, m_swd} !== {4'b1000, 32'h80808080}) begin n_fail++; $display("FAIL byte_st_lanes: got be=%b wdata=%h want 1000 80808080", m_be, m_swd); end
    run(0, 32'h13, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
    n_chk++; if ({m_be, m_rdata} !== {4'b1000, 32'hFFFFFF80}) begin n_fail++; $display("FAIL byte_ld_signed: got be=%b rdata=%h want 1000 ffffff80", m_be, m_rdata); end
    run(0, 32'h13, 1'b0, 2'd0, 1'b1, 32'h0, 1'b0);
    n_chk++; if (m_rdata !== 32'h00000080) begin n_fail++; $display("FAIL byte_ld_unsigned: got %h want 00000080", m_rdata); end
    run(0, 32'h12, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0);
    n_chk++; if ({m_be, m_rdata} !== {4'b1100, 32'hFFFF80AD}) begin n_fail++; $display("FAIL half_ld_signed: got be=%b rdata=%h want 1100 ffff80ad", m_be, m_rdata); end
    run(0, 32'h0E, 1'b1, 2'd1, 1'b0, 32'h1234_5678, 1'b0);
    n_chk++; if ({m_be, m_swd, m_sa} !== {4'b1100, 32'h56785678, 32'd3}) begin n_fail++; $display("FAIL half_st_lanes: got be=%b wdata=%h addr=%0d want 1100 56785678 3", m_be, m_swd, m_sa); end
  endtask
  task automatic test_errors;
    logic [31:0] addrs[3] = '{32'h11, 32'h12, 32'h10};
    logic [1:0]  sizes[3] = '{2'd1, 2'd2, 2'd3};
    for (int k = 0; k < 3; k++) begin
      run(0, addrs[k], 1'b0, sizes[k], 1'b0, 32'h0, 1'b0);
      n_chk++; if ({m_lat, m_err, m_rdata} !== {32'd1, 1'b1, 32'h0}) begin n_fail++; $display("FAIL err_resp_%0d: got lat=%0d err=%b rdata=%h want 1 1 0", k, m_lat, m_err, m_rdata); end
      n_chk++; if (m_en_cnt !== 0) begin n_fail++; $display("FAIL err_no_sram_%0d: got %0d accesses want 0", k, m_en_cnt); end
    end
  endtask
  task automatic test_range;
    int wc;
    wc = wcnt0;
    run(0, 32'h40, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
    n_chk++; if ({m_lat, m_err, m_en_cnt} !== {32'd1, 1'b1, 32'd0}) begin n_fail++; $display("FAIL range_ld_end: got lat=%0d err=%b en=%0d want 1 1 0", m_lat, m_err, m_en_cnt); end
    run(0, 32'hFFFF_FFFC, 1'b1, 2'd2, 1'b0, 32'hA5A5A5A5, 1'b0);
    n_chk++; if ({m_lat, m_err, m_en_cnt} !== {32'd1, 1'b1, 32'd0}) begin n_fail++; $display("FAIL range_st_top: got lat=%0d err=%b en=%0d want 1 1 0", m_lat, m_err, m_en_cnt); end
    @(negedge clk);
    n_chk++; if (wcnt0 !== wc) begin n_fail++; $display("FAIL range_no_write: got %0d writes want %0d", wcnt0, wc); end
    run(0, 32'h3C, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
    n_chk++; if ({m_lat, m_err, m_sa} !== {32'd3, 1'b0, 32'd15}) begin n_fail++; $display("FAIL range_last_word: got lat=%0d err=%b addr=%0d want 3 0 15", m_lat, m_err, m_sa); end
  endtask
  task automatic test_wait;
    run(1, 32'h20, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1);
    n_chk++; if (m_en_cyc !== 4 || m_en_cnt !== 1) begin n_fail++; $display("FAIL wait_en_cycle: got cyc=%0d cnt=%0d want 4 1", m_en_cyc, m_en_cnt); end
    n_chk++; if ({m_lat, m_err, m_rdata} !== {32'd6, 1'b0, 32'h0}) begin n_fail++; $display("FAIL wait_resp: got lat=%0d err=%b rdata=%h want 6 0 0", m_lat, m_err, m_rdata); end
    n_chk++; if (m_rdy_seen !== 1'b0) begin n_fail++; $display("FAIL wait_ready_low: got ready=1 during busy want 0"); end
  endtask
  task automatic test_reset_mid;
    int   wc;
    logic seen;
    for (int i = 0; i < 40 && !rdy[1]; i++) @(negedge clk);
    wc = wcnt1;
    req_addr = 32'h24; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++; if ({rdy[1], rv[1], er[1], en[1], swe[1], be[1], sa1, swd[1], rd[1]} !== '0) begin n_fail++; $display("FAIL rstmid_outs: got rdy=%b rv=%b en=%b be=%h wd=%h want all 0", rdy[1], rv[1], en[1], be[1], swd[1]); end
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (en[1] || rv[1]) seen = 1'b1; end
    rst = 1'b1;
    repeat (4) begin @(negedge clk); if (en[1] || rv[1]) seen = 1'b1; end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got sram_en/resp_valid after abort want none"); end
    n_chk++; if ({rdy[1], wcnt1} !== {1'b1, wc}) begin n_fail++; $display("FAIL rstmid_ready: got ready=%b writes=%0d want 1 %0d", rdy[1], wcnt1, wc); end
    run(1, 32'h24, 1'b1, 2'd2, 1'b0, 32'h1357_9BDF, 1'b0);
    n_chk++; if ({m_lat, m_err, m_sa} !== {32'd5, 1'b0, 32'd9}) begin n_fail++; $display("FAIL rstmid_store: got lat=%0d err=%b addr=%0d want 5 0 9", m_lat, m_err, m_sa); end
    run(1, 32'h24, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
    n_chk++; if ({m_lat, m_rdata} !== {32'd6, 32'h13579BDF}) begin n_fail++; $display("FAIL rstmid_load: got lat=%0d rdata=%h want 6 13579bdf", m_lat, m_rdata); end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem0[i] = '0;
    for (int i = 0; i < 16384; i++) mem1[i] = '0;
    test_reset;
    test_word;
    test_byte;
    test_errors;
    test_range;
    test_wait;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
